// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the data memory and data_mem_arbiter.
// slave: the arbiter's view; master: the requester/memory side.
interface data_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_a;
  logic [31:0] dbg_wd;
  logic        cpu_gnt;
  logic        dbg_gnt;
  logic        cpu_done;
  logic        dbg_done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_a, cpu_wd,
    input  dbg_req, dbg_we, dbg_a, dbg_wd,
    input  mem_rd,
    output cpu_gnt, dbg_gnt, cpu_done, dbg_done, rdata, err,
    output mem_a, mem_wd, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_a, cpu_wd,
    output dbg_req, dbg_we, dbg_a, dbg_wd,
    output mem_rd,
    input  cpu_gnt, dbg_gnt, cpu_done, dbg_done, rdata, err,
    input  mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU/debug) round-robin arbiter in front of a single-cycle data memory.
// Optional ARB_RANGE_CHECK_EN adds an out-of-range word check against MEM_WORDS.
module data_mem_arbiter #(
  parameter int MEM_WORDS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        last_dbg_reg;
  logic        win_dbg_reg;
  logic        we_reg;
  logic [31:0] a_reg;
  logic [31:0] wd_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        any_req;
  logic        sel_dbg;
  logic        oor;

  assign any_req = bus.cpu_req | bus.dbg_req;
  // On a tie the port that was not served last wins.
  assign sel_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg_reg);

`ifdef ARB_RANGE_CHECK_EN
  assign oor = ({2'b00, a_reg[31:2]} >= 32'(MEM_WORDS));
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_WORDS > 0);
  assign oor        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch at grant and response capture at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_reg <= 1'b1;
      win_dbg_reg  <= 1'b0;
      we_reg       <= 1'b0;
      a_reg        <= '0;
      wd_reg       <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg == IDLE && any_req) begin
        win_dbg_reg  <= sel_dbg;
        last_dbg_reg <= sel_dbg;
        we_reg       <= sel_dbg ? bus.dbg_we : bus.cpu_we;
        a_reg        <= sel_dbg ? bus.dbg_a  : bus.cpu_a;
        wd_reg       <= sel_dbg ? bus.dbg_wd : bus.cpu_wd;
      end
      if (state_reg == ACCESS) begin
        rdata_reg <= (we_reg | oor) ? 32'h0 : bus.mem_rd;
        err_reg   <= oor;
      end
    end
  end

  always_comb begin
    bus.cpu_gnt  = 1'b0;
    bus.dbg_gnt  = 1'b0;
    bus.cpu_done = 1'b0;
    bus.dbg_done = 1'b0;
    bus.mem_we   = 1'b0;
    case (state_reg)
      ACCESS: begin
        bus.cpu_gnt = ~win_dbg_reg;
        bus.dbg_gnt = win_dbg_reg;
        bus.mem_we  = we_reg & ~oor;
      end
      RESP: begin
        bus.cpu_done = ~win_dbg_reg;
        bus.dbg_done = win_dbg_reg;
      end
      default: ;
    endcase
  end

  // The latched address/data only change at a grant, so they hold between accesses.
  assign bus.mem_a  = a_reg;
  assign bus.mem_wd = wd_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter with a behavioural memory model.
// Honours ARB_RANGE_CHECK_EN when it is defined for the build.
module tb_data_mem_arbiter;
  localparam int MEM_WORDS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus();

  data_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Attached memory: 16 words, combinational read, write on posedge.
  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  bit          ref_last_dbg;
  int          n_cmp  = 0;
  int          n_fail = 0;

  assign bus.mem_rd = mem[bus.mem_a[5:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[5:2]] <= bus.mem_wd;

  function automatic bit model_oor(input logic [31:0] a);
`ifdef ARB_RANGE_CHECK_EN
    return (a >> 2) >= MEM_WORDS;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_a = 0; bus.cpu_wd = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_a = 0; bus.dbg_wd = 0;
  endtask

  task automatic test_reset();
    bus.cpu_req = 1; bus.dbg_req = 1; bus.cpu_we = 1; bus.cpu_a = 32'h8; bus.cpu_wd = 32'h55;
    tick(); tick(); tick();
    n_cmp++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.err, bus.mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.err, bus.mem_we});
    end
    n_cmp++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    n_cmp++;
    if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    n_cmp++;
    if (bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); end
    clear_inputs();
    rst_n = 1'b1;
    ref_last_dbg = 1'b1;
  endtask

  task automatic test_basic();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_a = 32'd8; bus.cpu_wd = 32'hDEADBEEF;
    tick();
    n_cmp++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.mem_we} !== 3'b101 || bus.mem_a !== 32'd8 || bus.mem_wd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_wr_access: gnt/dgnt/we=%b a=%h wd=%h want 101 a=8 wd=deadbeef",
               {bus.cpu_gnt, bus.dbg_gnt, bus.mem_we}, bus.mem_a, bus.mem_wd);
    end
    bus.cpu_req = 0;
    tick();
    ref_mem[2] = 32'hDEADBEEF;
    n_cmp++;
    if ({bus.cpu_done, bus.dbg_done, bus.err} !== 3'b100 || bus.rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_wr_done: done/ddone/err=%b rdata=%h want 100 rdata=0",
               {bus.cpu_done, bus.dbg_done, bus.err}, bus.rdata);
    end
    n_cmp++;
    if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_mem_word2: got %h want deadbeef", mem[2]); end
    $display("txn basic: cpu write a=00000008 wd=deadbeef");
    tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_a = 32'd8;
    tick();
    n_cmp++;
    if ({bus.cpu_gnt, bus.mem_we} !== 2'b10) begin
      n_fail++; $display("FAIL basic_rd_access: gnt/we=%b want 10", {bus.cpu_gnt, bus.mem_we});
    end
    bus.cpu_req = 0;
    tick();
    n_cmp++;
    if (bus.cpu_done !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_rd_done: done=%b rdata=%h want 1 deadbeef", bus.cpu_done, bus.rdata);
    end
    $display("txn basic: cpu read a=00000008 rdata=%h", bus.rdata);
    tick();
    ref_last_dbg = 1'b0;
  endtask

  task automatic test_freeze();
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_a = 32'd4; bus.dbg_wd = 32'h12345678;
    bus.cpu_a = 32'h20;
    tick();
    n_cmp++;
    if (bus.dbg_gnt !== 1'b1 || bus.mem_a !== 32'd4) begin
      n_fail++; $display("FAIL freeze_grant: dgnt=%b a=%h want 1 a=4", bus.dbg_gnt, bus.mem_a);
    end
    bus.dbg_req = 0; bus.cpu_a = 32'hFC; bus.dbg_a = 32'h3C; bus.dbg_wd = 32'h0;
    #3;
    n_cmp++;
    if (bus.mem_a !== 32'd4 || bus.mem_wd !== 32'h12345678) begin
      n_fail++; $display("FAIL freeze_mem_a: a=%h wd=%h want 4 12345678", bus.mem_a, bus.mem_wd);
    end
    tick();
    ref_mem[1] = 32'h12345678;
    n_cmp++;
    if (bus.dbg_done !== 1'b1 || mem[1] !== 32'h12345678) begin
      n_fail++; $display("FAIL freeze_done: ddone=%b word1=%h want 1 12345678", bus.dbg_done, mem[1]);
    end
    $display("txn freeze: dbg write a=00000004 wd=12345678");
    tick();
    ref_last_dbg = 1'b1;
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      bit cr, dr, win, we, oor;
      logic [31:0] ca, da, cw, dw, wa, wwd, exp_rd;
      logic cwe, dwe;
      cr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!cr && !dr) cr = 1'b1;
      ca = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      da = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      cw = $urandom; dw = $urandom;
      cwe = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
      bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_a = ca; bus.cpu_wd = cw;
      bus.dbg_req = dr; bus.dbg_we = dwe; bus.dbg_a = da; bus.dbg_wd = dw;
      win = dr && (!cr || !ref_last_dbg);
      wa  = win ? da : ca;
      we  = win ? dwe : cwe;
      wwd = win ? dw : cw;
      oor = model_oor(wa);
      exp_rd = (we || oor) ? 32'h0 : ref_mem[wa[5:2]];
      if (we && !oor) ref_mem[wa[5:2]] = wwd;
      tick();
      n_cmp++;
      if ({bus.cpu_gnt, bus.dbg_gnt} !== {!win, win} || bus.mem_a !== wa || bus.mem_we !== (we && !oor)) begin
        n_fail++;
        $display("FAIL rand_access[%0d]: gnt=%b a=%h we=%b want gnt=%b a=%h we=%b", t,
                 {bus.cpu_gnt, bus.dbg_gnt}, bus.mem_a, bus.mem_we, {!win, win}, wa, we && !oor);
      end
      bus.cpu_req = 0; bus.dbg_req = 0;
      bus.cpu_a = $urandom; bus.dbg_a = $urandom; bus.cpu_we = ~cwe; bus.dbg_we = ~dwe;
      tick();
      n_cmp++;
      if ({bus.cpu_done, bus.dbg_done} !== {!win, win} || bus.rdata !== exp_rd || bus.err !== oor) begin
        n_fail++;
        $display("FAIL rand_resp[%0d]: done=%b rdata=%h err=%b want done=%b rdata=%h err=%b", t,
                 {bus.cpu_done, bus.dbg_done}, bus.rdata, bus.err, {!win, win}, exp_rd, oor);
      end
      $display("txn %0d: %s %s a=%h wd=%h rdata=%h err=%0b", t, win ? "dbg" : "cpu",
               we ? "write" : "read ", wa, wwd, bus.rdata, bus.err);
      ref_last_dbg = win;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int g_port[$];
    int d_port[$];
    int d_cyc[$];
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ref_last_dbg = 1'b1;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_a = 32'd0;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_a = 32'd4;
    for (int c = 0; c < 30 && d_port.size() < 4; c++) begin
      tick();
      if (bus.cpu_gnt) g_port.push_back(0);
      if (bus.dbg_gnt) g_port.push_back(1);
      if (bus.cpu_done) begin d_port.push_back(0); d_cyc.push_back(c); end
      if (bus.dbg_done) begin d_port.push_back(1); d_cyc.push_back(c); end
    end
    clear_inputs();
    n_cmp++;
    if (g_port.size() != 4 || d_port.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: grants=%0d dones=%0d want 4 4", g_port.size(), d_port.size());
    end else begin
      bit exp_port = !ref_last_dbg;
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (g_port[k] != int'(exp_port) || d_port[k] != int'(exp_port)) begin
          n_fail++; $display("FAIL b2b_order[%0d]: gnt=%0d done=%0d want %0d", k, g_port[k], d_port[k], exp_port);
        end
        $display("txn b2b %0d: %s read", k, exp_port ? "dbg" : "cpu");
        if (k > 0) begin
          n_cmp++;
          if (d_cyc[k] - d_cyc[k-1] != 3) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", k, d_cyc[k] - d_cyc[k-1]);
          end
        end
        ref_last_dbg = exp_port;
        exp_port = !exp_port;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] new_wd;
    new_wd = ~ref_mem[0];
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_a = 32'd0; bus.cpu_wd = new_wd;
    tick();
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.cpu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: we=%b gnt=%b want 1 1", bus.mem_we, bus.cpu_gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.err, bus.mem_we} !== 6'b0 ||
        bus.rdata !== 32'h0 || bus.mem_a !== 32'h0 || bus.mem_wd !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: ctrl=%b rdata=%h a=%h wd=%h want all 0",
               {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.err, bus.mem_we},
               bus.rdata, bus.mem_a, bus.mem_wd);
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (mem[0] !== ref_mem[0]) begin
      n_fail++; $display("FAIL rst_mid_word0: got %h want %h", mem[0], ref_mem[0]);
    end
    rst_n = 1'b1;
    ref_last_dbg = 1'b1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_a = 32'd0;
    tick();
    n_cmp++;
    if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_mid_restart: gnt=%b want 1", bus.cpu_gnt); end
    bus.cpu_req = 0;
    tick();
    n_cmp++;
    if (bus.cpu_done !== 1'b1 || bus.rdata !== ref_mem[0]) begin
      n_fail++; $display("FAIL rst_mid_readback: done=%b rdata=%h want 1 %h", bus.cpu_done, bus.rdata, ref_mem[0]);
    end
    $display("txn rst_mid: cpu read a=00000000 rdata=%h", bus.rdata);
    ref_last_dbg = 1'b0;
    tick();
  endtask

  task automatic test_range();
    logic [31:0] wd;
    bit oor;
    wd = $urandom;
    oor = model_oor(32'd40);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_a = 32'd40; bus.cpu_wd = wd;
    tick();
    n_cmp++;
    if (bus.cpu_gnt !== 1'b1 || bus.mem_we !== !oor) begin
      n_fail++; $display("FAIL range_access: gnt=%b we=%b want 1 %b", bus.cpu_gnt, bus.mem_we, !oor);
    end
    bus.cpu_req = 0;
    tick();
    if (!oor) ref_mem[10] = wd;
    n_cmp++;
    if (bus.cpu_done !== 1'b1 || bus.err !== oor || bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL range_resp: done=%b err=%b rdata=%h want 1 %b 0", bus.cpu_done, bus.err, bus.rdata, oor);
    end
    n_cmp++;
    if (mem[10] !== ref_mem[10]) begin
      n_fail++; $display("FAIL range_word10: got %h want %h", mem[10], ref_mem[10]);
    end
    $display("txn range: cpu write a=00000028 err=%0b", bus.err);
    ref_last_dbg = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    clear_inputs();
    test_reset();
    test_basic();
    test_freeze();
    test_random(40);
    test_back_to_back();
    test_reset_mid_access();
    test_range();
    test_random(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 10: number of 32-bit words in the attached data memory; used only by the range check.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req, cpu_we  input  1 each  CPU port: access request and write enable.
REQ-005 cpu_a, cpu_wd  input  32 each  CPU port: byte address and write data.
REQ-006 dbg_req, dbg_we  input  1 each  debug port: access request and write enable.
REQ-007 dbg_a, dbg_wd  input  32 each  debug port: byte address and write data.
REQ-008 cpu_gnt, dbg_gnt  output  1 each  one-cycle pulse; the port's access is being performed.
REQ-009 cpu_done, dbg_done  output  1 each  one-cycle pulse; access complete, rdata/err valid.
REQ-010 rdata  output  32  read data of the completed access; shared by both ports.
REQ-011 err  output  1  out-of-range access flag, valid with done.
REQ-012 mem_a, mem_wd  output  32 each  to data memory address and write-data pins.
REQ-013 mem_we  output  1  to data memory write enable.
REQ-014 mem_rd  input  32  from data memory read data; combinational from mem_a.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when either req is high at posedge.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 Requests are sampled only in IDLE. A req high in ACCESS or RESP is not lost: it is sampled on the next IDLE cycle if still high.
REQ-017 Winner selection at the IDLE->ACCESS edge:
- single requester wins;
- if both request, the port not served last wins;
- last_served register resets to dbg, so the CPU wins the first tie.
REQ-018 At the IDLE->ACCESS edge, the winner's a/we/wd are latched. Later changes to requester inputs do not affect the access in progress.
REQ-019 In ACCESS: mem_a = latched address, mem_wd = latched data, mem_we = latched we; winner's gnt = 1.
REQ-020 Outside ACCESS: mem_we = 0; mem_a and mem_wd hold their last value; both gnt = 0.
REQ-021 At the ACCESS->RESP edge:
- rdata <= mem_rd for reads;
- rdata <= 0 for writes;
- the write takes effect in the memory at this same edge.
REQ-022 In RESP: winner's done = 1 and rdata/err valid; rdata and err hold until the next RESP.
REQ-023 Latency from req sampled to done is exactly 2 cycles; maximum throughput is one access per 3 cycles.
REQ-024 The requester drops req in the cycle done is seen. A req still high when IDLE is re-entered starts a new access.
REQ-025 Back-to-back with both ports continuously requesting: grants strictly alternate cpu, dbg, cpu, ...
REQ-026 Address low two bits are passed to mem_a unchanged; no alignment check.

Reset
REQ-027 While rst_n = 0, independent of clk:
- state = IDLE, last_served = dbg;
- all gnt, done, err, mem_we = 0;
- rdata, mem_a, mem_wd = 0.
REQ-028 Reset asserted during ACCESS abandons the access; mem_we drops immediately, so no write is performed unless a posedge preceded the reset.
REQ-029 After rst_n rises, the first posedge samples requests normally.

Configuration
REQ-030 Macro ARB_RANGE_CHECK_EN.
- Defined: an access with (latched address >> 2) >= MEM_WORDS is out of range:
  - mem_we is forced 0 during ACCESS;
  - rdata = 0 and err = 1 in RESP;
  - gnt/done timing is unchanged.
- Undefined: err is constant 0 and no address check exists.

Verification
REQ-031 Reset, then cpu_req = 1, cpu_we = 1, cpu_a = 8, cpu_wd = 0xDEADBEEF -> cpu_gnt 1 cycle later, cpu_done 2 cycles later; a following read of address 8 returns rdata = 0xDEADBEEF.
REQ-032 cpu_req and dbg_req both raised in the same cycle after reset, both held -> grant order cpu, dbg, cpu, dbg; done pulses 3 cycles apart.
REQ-033 dbg write of 0x12345678 to address 4; cpu_a changes during ACCESS -> mem_a stays 4 throughout ACCESS; dbg_done asserted; memory word 1 = 0x12345678.
REQ-034 rst_n pulled low mid-ACCESS of a cpu write to address 0 -> mem_we drops immediately, word 0 unchanged, all outputs 0, state IDLE.
REQ-035 With ARB_RANGE_CHECK_EN: cpu write to address 40 with MEM_WORDS = 10 -> mem_we stays 0, err = 1 and rdata = 0 with cpu_done. Without the macro, the same stimulus gives err = 0.
